// File: rtl/clkdiv_prog_pkg.sv
// Shared constants and helpers for the programmable multi-channel clock divider.
package clkdiv_prog_pkg;

  localparam int TICK_CNT_W = 16;

  // High time of one period: ceil(D/2) cycles.
  function automatic logic [31:0] hi_time(input logic [31:0] d);
    return d - (d >> 1);
  endfunction

  // A divisor of 1 cannot produce a low phase, so it runs as 2.
  function automatic logic [31:0] eff_div(input logic [31:0] d);
    return (d == 32'd1) ? 32'd2 : d;
  endfunction

endpackage

// File: rtl/clkdiv_prog_ch.sv
// One divider channel: divisor/counter, staged divisor applied at a period boundary.
// Optional per-channel tick counter when CLKDIV_PROG_CNT_EN is defined.
module clkdiv_prog_ch
  import clkdiv_prog_pkg::*;
#(
  parameter int W       = 16,
  parameter int DEF_DIV = 2
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         load_vld,
  input  logic [W-1:0] load_div,
  output logic         pending,
  output logic         clk_out,
  output logic         tick
`ifdef CLKDIV_PROG_CNT_EN
  ,
  output logic [TICK_CNT_W-1:0] tick_cnt
`endif
);

  logic [W-1:0] div_q, div_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] stage_q, stage_d;
  logic         pending_q, pending_d;
  logic         clk_out_q, clk_out_d;
  logic         tick_q, tick_d;
  logic         stopped;
  logic         boundary;

  // A stopped channel (D==0) treats every edge as a boundary so a new divisor applies at once.
  assign stopped  = (div_q == '0);
  assign boundary = stopped || (cnt_q == div_q - W'(1));

  always_comb begin
    div_d     = div_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    pending_d = pending_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    if (boundary) begin
      cnt_d = '0;
      if (pending_q) begin
        div_d     = W'(eff_div(32'(stage_q)));
        pending_d = 1'b0;
        clk_out_d = (stage_q != '0);
        tick_d    = (stage_q != '0);
      end else begin
        clk_out_d = !stopped;
        tick_d    = !stopped;
      end
    end else begin
      cnt_d     = cnt_q + W'(1);
      clk_out_d = (cnt_d < W'(hi_time(32'(div_q))));
    end
    // Staging never collides with apply: load_vld only fires while pending_q is clear.
    if (load_vld) begin
      stage_d   = load_div;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= W'(DEF_DIV);
      cnt_q     <= W'(DEF_DIV - 1);
      stage_q   <= '0;
      pending_q <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign pending = pending_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

`ifdef CLKDIV_PROG_CNT_EN
  logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q + TICK_CNT_W'(tick_q);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

  assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: rtl/clkdiv_prog.sv
// Multi-channel runtime-programmable clock divider: config decode plus NCH channel instances.
// Optional tick_cnt output per channel when CLKDIV_PROG_CNT_EN is defined.
module clkdiv_prog
  import clkdiv_prog_pkg::*;
#(
  parameter int  NCH     = 4,
  parameter int  W       = 16,
  parameter int  DEF_DIV = 2,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_in,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [W-1:0]   cfg_div,
  output logic [NCH-1:0] cfg_pending,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
`ifdef CLKDIV_PROG_CNT_EN
  ,
  output logic [NCH*TICK_CNT_W-1:0] tick_cnt
`endif
);

  logic               ch_oor;
  logic [2**CHW-1:0]  pend_ext;

  // Out-of-range channels are always ready and silently discarded.
  assign ch_oor = (int'(cfg_ch) >= NCH);

  always_comb begin
    pend_ext             = '0;
    pend_ext[NCH-1:0]    = cfg_pending;
  end

  assign cfg_ready = ch_oor | ~pend_ext[cfg_ch];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic load_vld;
    assign load_vld = cfg_valid & cfg_ready & ~ch_oor & (cfg_ch == CHW'(c));

    clkdiv_prog_ch #(
      .W       (W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .load_vld (load_vld),
      .load_div (cfg_div),
      .pending  (cfg_pending[c]),
      .clk_out  (clk_out[c]),
      .tick     (tick[c])
`ifdef CLKDIV_PROG_CNT_EN
      ,
      .tick_cnt (tick_cnt[c*TICK_CNT_W +: TICK_CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_clkdiv_prog.sv
// Bench for clkdiv_prog: directed scenarios plus random config traffic against a countdown model.
module tb_clkdiv_prog;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch  = '0;
  logic [15:0] cfg_div = '0;
  logic [3:0]  cfg_pending, clk_out, tick;

  logic        c3_valid = 1'b0;
  logic        c3_ready;
  logic [1:0]  c3_ch  = '0;
  logic [15:0] c3_div = '0;
  logic [2:0]  c3_pend, c3_clk, c3_tick;

`ifdef CLKDIV_PROG_CNT_EN
  logic [63:0] tick_cnt;
  logic [47:0] c3_tick_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  clkdiv_prog #(.NCH(4), .W(16), .DEF_DIV(2)) u_dut (
    .clk_in(clk_in), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_pending(cfg_pending),
    .clk_out(clk_out), .tick(tick)
`ifdef CLKDIV_PROG_CNT_EN
    , .tick_cnt(tick_cnt)
`endif
  );

  clkdiv_prog #(.NCH(3), .W(16), .DEF_DIV(2)) u_dut3 (
    .clk_in(clk_in), .rst_n(rst_n), .cfg_valid(c3_valid), .cfg_ready(c3_ready),
    .cfg_ch(c3_ch), .cfg_div(c3_div), .cfg_pending(c3_pend),
    .clk_out(c3_clk), .tick(c3_tick)
`ifdef CLKDIV_PROG_CNT_EN
    , .tick_cnt(c3_tick_cnt)
`endif
  );

  // Reference model: each channel counts down the edges left in its period; the last D/2 are low.
  int          m_d[4];
  int          m_rem[4];
  int          m_stage[4];
  logic [3:0]  m_pend, m_clk, m_tick;
  bit          m_acc;
  logic [15:0] m_tcnt[4];

  always @(posedge clk_in or negedge rst_n) begin : model
    bit acc;
    int ach;
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        m_d[c] = 2; m_rem[c] = 0; m_stage[c] = 0; m_tcnt[c] = '0;
      end
      m_pend = '0; m_clk = '0; m_tick = '0; m_acc = 0;
    end else begin
      ach = int'(cfg_ch);
      acc = cfg_valid && !m_pend[ach];
      for (int c = 0; c < 4; c++) begin
        m_tcnt[c] = m_tcnt[c] + 16'(m_tick[c]);
        if (m_d[c] == 0 || m_rem[c] == 0) begin
          if (m_pend[c]) begin
            m_d[c] = (m_stage[c] == 1) ? 2 : m_stage[c];
            m_pend[c] = 1'b0;
          end
          if (m_d[c] == 0) begin
            m_rem[c] = 0; m_clk[c] = 1'b0; m_tick[c] = 1'b0;
          end else begin
            m_rem[c] = m_d[c] - 1; m_clk[c] = 1'b1; m_tick[c] = 1'b1;
          end
        end else begin
          m_rem[c] = m_rem[c] - 1;
          m_clk[c] = (m_rem[c] >= m_d[c] / 2);
          m_tick[c] = 1'b0;
        end
      end
      if (acc) begin
        m_stage[ach] = int'(cfg_div);
        m_pend[ach] = 1'b1;
      end
      m_acc = acc;
    end
  end

  task automatic test_reset();
    bit exp_clk[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if (clk_out !== 4'b0 || tick !== 4'b0 || cfg_pending !== 4'b0 || cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state clk_out=%b tick=%b pend=%b rdy=%b required 0000 0000 0000 1",
               clk_out, tick, cfg_pending, cfg_ready);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      n_cmp++;
      if (clk_out[0] !== exp_clk[i] || tick[0] !== (i % 2 == 0)) begin
        n_bad++;
        $display("FAIL reset_seq edge %0d clk_out0=%b tick0=%b required %b %b",
                 i + 1, clk_out[0], tick[0], exp_clk[i], (i % 2 == 0));
      end
    end
  endtask

  task automatic test_load_mid_high();
    bit seq[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bit found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk_in);
      if (clk_out[1] === 1'b1) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL load_wait_high clk_out1 never high within 6 cycles");
    end
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd5;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_in);
      cfg_valid = 1'b0;
      n_cmp++;
      if (clk_out !== m_clk || tick !== m_tick || cfg_pending !== m_pend || cfg_ready !== !m_pend[cfg_ch]) begin
        n_bad++;
        $display("FAIL load_model t=%0t clk_out=%b/%b tick=%b/%b pend=%b/%b rdy=%b/%b", $time,
                 clk_out, m_clk, tick, m_tick, cfg_pending, m_pend, cfg_ready, !m_pend[cfg_ch]);
      end
      n_cmp++;
      if (clk_out[1] !== seq[i]) begin
        n_bad++;
        $display("FAIL load_seq step %0d clk_out1=%b required %b", i, clk_out[1], seq[i]);
      end
    end
  endtask

  task automatic test_stop_restart();
    bit seq[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      cfg_valid = 1'b0;
      n_cmp++;
      if (clk_out !== m_clk || tick !== m_tick || cfg_pending !== m_pend || cfg_ready !== !m_pend[cfg_ch]) begin
        n_bad++;
        $display("FAIL stop_model t=%0t clk_out=%b/%b tick=%b/%b pend=%b/%b rdy=%b/%b", $time,
                 clk_out, m_clk, tick, m_tick, cfg_pending, m_pend, cfg_ready, !m_pend[cfg_ch]);
      end
    end
    n_cmp++;
    if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0 || cfg_pending[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_held clk_out2=%b tick2=%b pend2=%b required 0 0 0",
               clk_out[2], tick[2], cfg_pending[2]);
    end
    cfg_valid = 1'b1; cfg_div = 16'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      cfg_valid = 1'b0;
      n_cmp++;
      if (clk_out[2] !== seq[i]) begin
        n_bad++;
        $display("FAIL restart_seq step %0d clk_out2=%b required %b", i, clk_out[2], seq[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit done = 0;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd7;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk_in);
      cfg_valid = 1'b0;
      if (m_pend[0] == 1'b0 && i > 0) done = 1;
    end
    cfg_valid = 1'b1; cfg_div = 16'd4;
    @(negedge clk_in);
    cfg_div = 16'd6;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (cfg_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_stall step %0d cfg_ready=%b required 0", i, cfg_ready);
      end
      @(negedge clk_in);
    end
    cfg_ch = 2'd3; cfg_div = 16'd3;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_other_ch cfg_ready=%b required 1", cfg_ready);
    end
    @(negedge clk_in);
    cfg_ch = 2'd0; cfg_div = 16'd6;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk_in);
      n_cmp++;
      if (clk_out !== m_clk || tick !== m_tick || cfg_pending !== m_pend || cfg_ready !== !m_pend[cfg_ch]) begin
        n_bad++;
        $display("FAIL b2b_model t=%0t clk_out=%b/%b tick=%b/%b pend=%b/%b rdy=%b/%b", $time,
                 clk_out, m_clk, tick, m_tick, cfg_pending, m_pend, cfg_ready, !m_pend[cfg_ch]);
      end
      if (m_acc) done = 1;
    end
    cfg_valid = 1'b0;
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL b2b_timeout held ch0 write not accepted within 20 cycles");
    end
  endtask

  task automatic test_d1_and_oor();
    bit done = 0;
    logic [2:0] prev;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd1;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk_in);
      if (m_acc) begin done = 1; cfg_valid = 1'b0; end
    end
    cfg_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_in);
      n_cmp++;
      if (clk_out !== m_clk || tick !== m_tick || cfg_pending !== m_pend || cfg_ready !== !m_pend[cfg_ch]) begin
        n_bad++;
        $display("FAIL d1_model t=%0t clk_out=%b/%b tick=%b/%b pend=%b/%b rdy=%b/%b", $time,
                 clk_out, m_clk, tick, m_tick, cfg_pending, m_pend, cfg_ready, !m_pend[cfg_ch]);
      end
    end
    n_cmp++;
    if (!done || m_d[0] != 2) begin
      n_bad++;
      $display("FAIL d1_accept accepted=%0d model_div=%0d required 1 2", done, m_d[0]);
    end
    prev = c3_clk;
    c3_valid = 1'b1; c3_ch = 2'd3; c3_div = 16'd0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (c3_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL oor_ready step %0d c3_ready=%b required 1", i, c3_ready);
      end
      @(negedge clk_in);
      n_cmp++;
      if (c3_pend !== 3'b000 || c3_clk !== ~prev) begin
        n_bad++;
        $display("FAIL oor_nochange step %0d pend=%b clk=%b required 000 %b", i, c3_pend, c3_clk, ~prev);
      end
      prev = c3_clk;
    end
    c3_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_in);
      n_cmp++;
      if (clk_out !== m_clk || tick !== m_tick || cfg_pending !== m_pend || cfg_ready !== !m_pend[cfg_ch]) begin
        n_bad++;
        $display("FAIL rand_model cyc %0d clk_out=%b/%b tick=%b/%b pend=%b/%b rdy=%b/%b", i,
                 clk_out, m_clk, tick, m_tick, cfg_pending, m_pend, cfg_ready, !m_pend[cfg_ch]);
      end
      if (!cfg_valid || m_acc) begin
        cfg_valid = ($urandom_range(0, 2) == 0);
        cfg_ch    = 2'($urandom_range(0, 3));
        cfg_div   = 16'($urandom_range(0, 9));
      end
    end
    cfg_valid = 1'b0;
`ifdef CLKDIV_PROG_CNT_EN
    @(negedge clk_in);
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (tick_cnt[c*16 +: 16] !== m_tcnt[c]) begin
        n_bad++;
        $display("FAIL tick_cnt ch%0d got %0d required %0d", c, tick_cnt[c*16 +: 16], m_tcnt[c]);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_high();
    bit found = 0;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd6;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk_in);
      if (m_acc) cfg_valid = 1'b0;
      if (!cfg_valid && m_pend[0] == 1'b0 && m_d[0] == 6 && m_rem[0] == 4) found = 1;
    end
    cfg_valid = 1'b0;
    n_cmp++;
    if (!found || clk_out[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_setup found=%0d clk_out0=%b required 1 1", found, clk_out[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (clk_out !== 4'b0 || tick !== 4'b0 || cfg_pending !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_mid_high clk_out=%b tick=%b pend=%b required 0000 0000 0000",
               clk_out, tick, cfg_pending);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if (clk_out !== 4'b1111 || tick !== 4'b1111) begin
      n_bad++;
      $display("FAIL rst_mid_restart clk_out=%b tick=%b required 1111 1111", clk_out, tick);
    end
  endtask

  initial begin
    test_reset();
    test_load_mid_high();
    test_stop_restart();
    test_back_to_back();
    test_d1_and_oor();
    test_random();
    test_reset_mid_high();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
